fft_peak_detector: RTL and testbench

//  Downstream of the FFT core. Consumes one frame of FFT bin magnitudes (valid/ready stream, bin order 0..N_BINS-1).

---
 rtl/fft_peak_detector_pkg.sv | 23 ++
 rtl/fft_peak_detector_if.sv | 54 +++++
 rtl/fft_peak_detector_peak_compare.sv | 27 ++
 rtl/fft_peak_detector.sv | 106 ++++++++++
 tb/tb_fft_peak_detector.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_peak_detector_pkg.sv
// Shared defaults and state encoding for the FFT peak detector.
// Optional threshold feature: define PEAK_THRESH_EN.
package fft_peak_detector_pkg;

    localparam int DEF_MAG_W  = 32;
    localparam int DEF_N_BINS = 256;
    localparam int DEF_IDX_W  = $clog2(DEF_N_BINS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Usable half-spectrum: DC and the mirrored upper half are skipped.
    function automatic logic in_window(
        input int unsigned idx,
        input int unsigned n_bins
    );
        return (idx != 0) && (idx < n_bins / 2);
    endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// Magnitude stream, start/busy control and result handshake bundle.
// Threshold port and hit count exist only with PEAK_THRESH_EN.
interface fft_peak_detector_if
    import fft_peak_detector_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W,
    parameter int IDX_W = DEF_IDX_W
) ();

    logic             start;
    logic             busy;
    logic             mag_valid;
    logic [MAG_W-1:0] mag_data;
    logic             mag_last;
    logic             mag_ready;
    logic             peak_valid;
    logic             peak_ready;
    logic [IDX_W-1:0] peak_bin;
    logic [MAG_W-1:0] peak_mag;
    logic             frame_err;
`ifdef PEAK_THRESH_EN
    logic [MAG_W-1:0] thresh;
    logic [IDX_W-1:0] hit_cnt;

    modport master (
        output start, mag_valid, mag_data, mag_last,
        output peak_ready, thresh,
        input  busy, mag_ready, peak_valid,
        input  peak_bin, peak_mag, frame_err, hit_cnt
    );

    modport slave (
        input  start, mag_valid, mag_data, mag_last,
        input  peak_ready, thresh,
        output busy, mag_ready, peak_valid,
        output peak_bin, peak_mag, frame_err, hit_cnt
    );
`else
    modport master (
        output start, mag_valid, mag_data, mag_last,
        output peak_ready,
        input  busy, mag_ready, peak_valid,
        input  peak_bin, peak_mag, frame_err
    );

    modport slave (
        input  start, mag_valid, mag_data, mag_last,
        input  peak_ready,
        output busy, mag_ready, peak_valid,
        output peak_bin, peak_mag, frame_err
    );
`endif

endinterface

// File: rtl/fft_peak_detector_peak_compare.sv
// Registered running-max tracker; strict compare keeps the
// lowest index on ties.
module peak_compare #(
    parameter int MAG_W = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic [MAG_W-1:0] mag,
    output logic [IDX_W-1:0] best_idx,
    output logic [MAG_W-1:0] best_mag
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_idx <= '0;
            best_mag <= '0;
        end else if (en && (mag > best_mag)) begin
            best_idx <= idx;
            best_mag <= mag;
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Frame-level peak search over FFT bin magnitudes.
// Optional threshold/hit-count feature: define PEAK_THRESH_EN.
module fft_peak_detector
    import fft_peak_detector_pkg::*;
#(
    parameter int MAG_W  = DEF_MAG_W,
    parameter int N_BINS = DEF_N_BINS,
    parameter int IDX_W  = DEF_IDX_W
) (
    input logic               clk,
    input logic               rst,
    fft_peak_detector_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             err_q;
    logic             arm;
    logic             beat;
    logic             term;
    logic             at_last;
    logic             cmp_en;
    logic [IDX_W-1:0] best_idx;
    logic [MAG_W-1:0] best_mag;

    assign arm     = (state == ST_IDLE) && bus.start;
    assign beat    = (state == ST_SCAN) && bus.mag_valid;
    assign at_last = (cnt == LAST_IDX);
    assign term    = beat && (bus.mag_last || at_last);
    assign cmp_en  = beat && in_window(32'(cnt), N_BINS);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_SCAN;
            ST_SCAN:   if (term) state_nxt = ST_REPORT;
            ST_REPORT: if (bus.peak_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                cnt   <= '0;
                err_q <= 1'b0;
            end else if (term) begin
                // Error unless the marker lands exactly on the last bin.
                err_q <= bus.mag_last ^ at_last;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    peak_compare #(
        .MAG_W (MAG_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .clear    (arm),
        .en       (cmp_en),
        .idx      (cnt),
        .mag      (bus.mag_data),
        .best_idx (best_idx),
        .best_mag (best_mag)
    );

    assign bus.mag_ready  = (state == ST_SCAN);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.peak_valid = (state == ST_REPORT);
    assign bus.peak_mag   = best_mag;
    assign bus.frame_err  = err_q;

`ifdef PEAK_THRESH_EN
    logic [MAG_W-1:0] thresh_q;
    logic [IDX_W-1:0] hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            hit_q    <= '0;
        end else if (arm) begin
            thresh_q <= bus.thresh;
            hit_q    <= '0;
        end else if (cmp_en && (bus.mag_data >= thresh_q)) begin
            hit_q <= hit_q + 1'b1;
        end
    end

    assign bus.hit_cnt  = hit_q;
    assign bus.peak_bin = (best_mag < thresh_q) ? '1 : best_idx;
`else
    assign bus.peak_bin = best_idx;
`endif

endmodule

// File: tb/tb_fft_peak_detector.sv
// Randomized bench for fft_peak_detector against a frame-level model.
// Threshold checks are compiled in with PEAK_THRESH_EN.
module tb_fft_peak_detector;

    localparam int N     = 256;
    localparam int MAG_W = 32;
    localparam int IDX_W = 8;

    logic clk;
    logic rst;
    int   tests;
    int   errs;

    logic [MAG_W-1:0] mags [N];
    logic [MAG_W-1:0] thr;

    fft_peak_detector_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus ();

    fft_peak_detector #(
        .MAG_W  (MAG_W),
        .N_BINS (N),
        .IDX_W  (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level expectation: max over bins 1..N/2-1 that arrived,
    // first occurrence wins, error unless marker sits on bin N-1.
    task automatic model(input int t, input int last_at, output int eb,
                         output logic [MAG_W-1:0] em, output bit ee,
                         output int eh);
        eb = 0;
        em = '0;
        eh = 0;
        for (int k = 1; k < N / 2 && k <= t; k++) begin
            if (mags[k] > em) begin
                em = mags[k];
                eb = k;
            end
            if (mags[k] >= thr) eh++;
        end
        ee = !(t == N - 1 && last_at == N - 1);
`ifdef PEAK_THRESH_EN
        if (em < thr) eb = N - 1;
`endif
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, bus.peak_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ready"}, bus.mag_ready, 0);
        chk({tag, "_bin"}, bus.peak_bin, 0);
        chk({tag, "_mag"}, bus.peak_mag, 0);
        chk({tag, "_err"}, bus.frame_err, 0);
    endtask

    task automatic run_frame(input string tag, input int last_at,
                             input int abort_at, input int start_at,
                             input int gap_pct, input int bp);
        int t, k, cyc, eb, eh;
        logic [MAG_W-1:0] em;
        bit ee, acc, stable;
        logic [IDX_W-1:0] sb;
        logic [MAG_W-1:0] sm;
        logic se;
        t = (last_at >= 0 && last_at < N - 1) ? last_at : N - 1;
        @(posedge clk); #1;
        bus.start = 1'b1;
`ifdef PEAK_THRESH_EN
        bus.thresh = thr;
`endif
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        k = 0;
        cyc = 0;
        while (k <= t && cyc < 5000) begin
            if (k == abort_at) begin
                bus.mag_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk_cleared({tag, "_abort"});
                return;
            end
            bus.mag_valid  = ($urandom_range(99) >= gap_pct);
            bus.mag_data   = mags[k];
            bus.mag_last   = (k == last_at);
            bus.start      = (k == start_at);
            bus.peak_ready = 1'($urandom_range(1));
            acc = bus.mag_valid && bus.mag_ready;
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (acc) k++;
        end
        bus.peak_ready = 1'b0;
        chk({tag, "_timeout"}, cyc >= 5000, 0);
        chk({tag, "_latency"}, bus.peak_valid, 1);
        bus.mag_valid = 1'b1;
        bus.mag_last  = 1'b0;
        bus.mag_data  = $urandom;
        chk({tag, "_rdy_off"}, bus.mag_ready, 0);
        model(t, last_at, eb, em, ee, eh);
        chk({tag, "_bin"}, bus.peak_bin, eb);
        chk({tag, "_mag"}, bus.peak_mag, em);
        chk({tag, "_err"}, bus.frame_err, ee);
`ifdef PEAK_THRESH_EN
        chk({tag, "_hits"}, bus.hit_cnt, eh);
`endif
        sb = bus.peak_bin;
        sm = bus.peak_mag;
        se = bus.frame_err;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            bus.start = (i == 0);
            @(posedge clk); #1;
            bus.start = 1'b0;
            stable &= bus.peak_valid && !bus.mag_ready;
            stable &= (bus.peak_bin == sb) && (bus.peak_mag == sm);
            stable &= (bus.frame_err == se);
        end
        if (bp > 0) chk({tag, "_hold"}, stable, 1);
        bus.mag_valid  = 1'b0;
        bus.peak_ready = 1'b1;
        @(posedge clk); #1;
        bus.peak_ready = 1'b0;
        chk({tag, "_done_valid"}, bus.peak_valid, 0);
        chk({tag, "_done_busy"}, bus.busy, 0);
    endtask

    initial begin
        int la;
        tests = 0;
        errs  = 0;
        thr   = '0;
        rst   = 1'b1;
        bus.start      = 1'b0;
        bus.mag_valid  = 1'b0;
        bus.mag_data   = '0;
        bus.mag_last   = 1'b0;
        bus.peak_ready = 1'b0;
`ifdef PEAK_THRESH_EN
        bus.thresh = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b0;

        for (int i = 0; i < N; i++) mags[i] = i;
        run_frame("ramp", N - 1, -1, -1, 0, 0);

        for (int i = 0; i < N; i++) mags[i] = 0;
        mags[0]   = 1000;
        mags[200] = 900;
        mags[5]   = 50;
        run_frame("dc", N - 1, -1, -1, 20, 2);

        for (int i = 0; i < N; i++) mags[i] = 0;
        mags[10] = 77;
        mags[20] = 77;
        run_frame("tie", N - 1, -1, -1, 0, 1);

        for (int i = 0; i < N; i++) mags[i] = 0;
        run_frame("zero", N - 1, -1, -1, 10, 0);

        for (int i = 0; i < N; i++) mags[i] = $urandom;
        run_frame("short", 99, -1, -1, 0, 5);
        run_frame("long", -1, -1, -1, 15, 3);

        for (int i = 0; i < N; i++) mags[i] = i;
        run_frame("abort", N - 1, 60, -1, 0, 0);
        run_frame("reramp", N - 1, -1, 30, 25, 2);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++)
                mags[i] = (f % 2 == 0) ? $urandom_range(40) : $urandom;
            case ($urandom_range(3))
                0: la = N - 1;
                1: la = -1;
                2: la = $urandom_range(N - 2);
                default: la = $urandom_range(N - 2, 130);
            endcase
            run_frame("rand", la, -1, $urandom_range(300), 30,
                      $urandom_range(4));
        end

`ifdef PEAK_THRESH_EN
        for (int i = 0; i < N; i++) mags[i] = i;
        thr = 100;
        run_frame("thr100", N - 1, -1, -1, 0, 1);
        thr = 200;
        run_frame("thr200", N - 1, -1, -1, 0, 1);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) mags[i] = $urandom_range(500);
            thr = $urandom_range(520);
            run_frame("thr_rand", N - 1, -1, -1, 20, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
